// File: rtl/zle_stream_arb_if.sv
// zle_stream_arb_if: source-side, encoder-side and grant-status signals of the arbiter.
//   s_d/s_v/s_b : N packed 3-bit token streams with valid and backpressure.
//   e_d/e_v/e_b : token stream toward the zero run-length encoder.
//   g_v/g_id/sw : grant active, current owner index, new-grant pulse.
interface zle_stream_arb_if #(parameter int N = 4);
   logic [3*N-1:0] s_d;
   logic [N-1:0]   s_v;
   logic [N-1:0]   s_b;
   logic [2:0]     e_d;
   logic           e_v;
   logic           e_b;
   logic           g_v;
   logic [1:0]     g_id;
   logic           sw;
   modport master (output s_d, s_v, e_b, input s_b, e_d, e_v, g_v, g_id, sw);
   modport slave  (input s_d, s_v, e_b, output s_b, e_d, e_v, g_v, g_id, sw);
endinterface

// File: rtl/zle_stream_arb.sv
// zle_stream_arb: round-robin arbiter sharing one zero run-length encoder among N token streams.
//   clock : system clock, rising edge.
//   reset : asynchronous active-low reset.
//   bus   : source streams in, encoder stream out, grant status out.
// Ownership only changes when the encoder's zero-run count is back at zero, so a run is never split.
module zle_stream_arb #(
   parameter int N        = 4,
   parameter int BURST    = 8,
   parameter int IDLE_MAX = 4
) (
   input logic             clock,
   input logic             reset,
   zle_stream_arb_if.slave bus
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t     r_state;
   logic [1:0] r_last, r_g_id;
   logic       r_sw;
   logic [7:0] r_bcnt;
   logic [3:0] r_zcnt, r_icnt;
   logic [2:0] w_src [4];
   logic [3:0] w_sv;
   logic [2:0] w_tok;
   logic       w_own_v, w_xfer, w_rel;
   logic [1:0] w_win, w_j;
   logic [7:0] w_bcnt;
   logic [3:0] w_zcnt, w_icnt;

   for (genvar k = 0; k < 4; k++) begin : g_src
      if (k < N) begin : g_on
         assign w_src[k]   = bus.s_d[3*k +: 3];
         assign bus.s_b[k] = ~(r_state == GRANT && r_g_id == 2'(k)) | bus.e_b;
      end else begin : g_off
         assign w_src[k] = '0;
      end
   end

   assign w_sv     = 4'(bus.s_v);
   assign w_tok    = w_src[r_g_id];
   assign w_own_v  = w_sv[r_g_id];
   assign bus.e_d  = w_tok;
   assign bus.e_v  = (r_state == GRANT) && w_own_v;
   assign bus.g_v  = (r_state == GRANT);
   assign bus.g_id = r_g_id;
   assign bus.sw   = r_sw;
   assign w_xfer   = bus.e_v & ~bus.e_b;
   // zcnt wraps 15->0 on its own: the encoder emits a full run at that point
   assign w_zcnt   = !w_xfer ? r_zcnt : (w_tok != 3'd0) ? 4'd0 : r_zcnt + 4'd1;
   assign w_bcnt   = (w_xfer && r_bcnt != 8'hFF) ? r_bcnt + 8'd1 : r_bcnt;
   assign w_icnt   = w_own_v ? 4'd0 : (r_icnt == 4'(IDLE_MAX)) ? r_icnt : r_icnt + 4'd1;
   assign w_rel    = (w_zcnt == 4'd0) && ((w_xfer && w_bcnt >= 8'(BURST)) || w_icnt == 4'(IDLE_MAX));

   // Scan downward so the source nearest after r_last overwrites the others
   always_comb begin
      w_win = r_last;
      w_j   = '0;
      for (int i = N; i >= 1; i--) begin
         w_j = 2'((int'(r_last) + i) % N);
         if (w_sv[w_j]) w_win = w_j;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_last  <= 2'(N - 1);
         r_g_id  <= '0;
         r_sw    <= 1'b0;
         r_bcnt  <= '0;
         r_zcnt  <= '0;
         r_icnt  <= '0;
      end else begin
         r_sw <= 1'b0;
         if (r_state == IDLE) begin
            if (|bus.s_v) begin
               r_state <= GRANT;
               r_g_id  <= w_win;
               r_last  <= w_win;
               r_sw    <= 1'b1;
            end
         end else if (w_rel) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_zcnt  <= '0;
            r_icnt  <= '0;
         end else begin
            r_bcnt <= w_bcnt;
            r_zcnt <= w_zcnt;
            r_icnt <= w_icnt;
         end
      end
   end
endmodule

// File: tb/tb_zle_stream_arb.sv
// tb_zle_stream_arb: token-queue sources plus a transfer-history model checked every cycle.
module tb_zle_stream_arb;
   localparam int N = 4, BURST = 8, IDLE_MAX = 4;
   logic clock = 1'b0, reset = 1'b0;
   zle_stream_arb_if #(.N(N)) bus ();
   zle_stream_arb #(.N(N), .BURST(BURST), .IDLE_MAX(IDLE_MAX)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;

   int   q[N][$];
   logic eb;
   bit   m_gv, m_sw;
   int   m_own, m_last, m_len, m_zrun, m_idle;
   int   vectors, miscompares, cyc;
   int   ids[$], cnts[$], lens[$], swc[$];

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic int at(int qq[$], int i);
      return (i < qq.size()) ? qq[i] : -1;
   endfunction

   task automatic drive();
      logic [N-1:0]   v;
      logic [3*N-1:0] d;
      for (int k = 0; k < N; k++) begin
         v[k]         = q[k].size() > 0;
         d[3*k +: 3]  = v[k] ? 3'(q[k][0]) : 3'd0;
      end
      bus.s_v = v;
      bus.s_d = d;
      bus.e_b = eb;
   endtask

   // Expected outputs come from the model's owner/grant flags and the driven inputs
   task automatic compare();
      logic [N-1:0] sb;
      logic [2:0]   ed;
      logic         ev;
      ev = m_gv && bus.s_v[m_own];
      ed = ev ? bus.s_d[3*m_own +: 3] : 3'd0;
      for (int k = 0; k < N; k++) sb[k] = (m_gv && k == m_own) ? eb : 1'b1;
      chk("outputs{g_v,g_id,sw,e_v,s_b,e_d}",
          {20'd0, bus.g_v, bus.g_id, bus.sw, bus.e_v, bus.s_b, (ev ? bus.e_d : 3'd0)},
          {20'd0, m_gv, 2'(m_own), m_sw, ev, sb, ed});
      if (bus.sw) begin
         ids.push_back(int'(bus.g_id));
         cnts.push_back(0);
         lens.push_back(0);
         swc.push_back(cyc);
      end
      if (bus.g_v && lens.size() > 0) lens[lens.size()-1]++;
      if (bus.e_v && !bus.e_b && cnts.size() > 0) cnts[cnts.size()-1]++;
   endtask

   // Boundary = the trailing zero run of this grant is a whole number of 16-zero runs
   task automatic update();
      logic [N-1:0] sv;
      bit xfer;
      int tok;
      sv   = bus.s_v;
      xfer = m_gv && sv[m_own] && !eb;
      m_sw = 1'b0;
      if (!m_gv) begin
         for (int i = 1; i <= N && !m_gv; i++)
            if (sv[(m_last + i) % N]) begin
               m_own = (m_last + i) % N;
               m_last = m_own;
               m_gv = 1'b1;
               m_sw = 1'b1;
               m_len = 0;
               m_zrun = 0;
               m_idle = 0;
            end
      end else begin
         if (xfer) begin
            tok = q[m_own].pop_front();
            m_len++;
            m_zrun = (tok == 0) ? m_zrun + 1 : 0;
         end
         m_idle = sv[m_own] ? 0 : m_idle + 1;
         if (m_zrun % 16 == 0 && ((xfer && m_len >= BURST) || m_idle >= IDLE_MAX)) m_gv = 1'b0;
      end
   endtask

   task automatic step(int n);
      for (int i = 0; i < n; i++) begin
         drive();
         @(negedge clock);
         compare();
         @(posedge clock);
         if (reset) update();
         cyc++;
         #1;
      end
   endtask

   task automatic hard_reset(bit clr);
      #2 reset = 1'b0;
      #1;
      chk("reset g_v", 32'(bus.g_v), 32'd0);
      chk("reset e_v", 32'(bus.e_v), 32'd0);
      chk("reset s_b", 32'(bus.s_b), 32'hF);
      m_gv = 1'b0;
      m_sw = 1'b0;
      m_own = 0;
      m_last = N - 1;
      ids = {};
      cnts = {};
      lens = {};
      swc = {};
      eb = 1'b0;
      if (clr) for (int k = 0; k < N; k++) q[k] = {};
      drive();
      @(posedge clock);
      #2 reset = 1'b1;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      cyc = 0;
      eb = 1'b0;
      drive();
      @(posedge clock);
      #1;
      // all four streaming nonzero tokens: 0,1,2,3,0 with 8 transfers each
      hard_reset(1);
      for (int k = 0; k < N; k++) for (int i = 0; i < 16; i++) q[k].push_back(k + 1);
      step(44);
      for (int i = 0; i < 5; i++) chk($sformatf("rr id %0d", i), at(ids, i), (i == 4) ? 0 : i);
      for (int i = 0; i < 4; i++) chk($sformatf("rr xfers %0d", i), at(cnts, i), 8);
      for (int i = 0; i < 4; i++) chk($sformatf("rr grant cycles %0d", i), at(lens, i), 8);
      chk("rr sw spacing", at(swc, 1) - at(swc, 0), 9);
      // 7 nonzero, 3 zeros, then 5: no release at 8th token
      hard_reset(1);
      q[1] = {1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 5, 6};
      step(25);
      chk("run id", at(ids, 0), 1);
      chk("run xfers", at(cnts, 0), 11);
      chk("run grant cycles", at(lens, 0), 11);
      chk("run regrant id", at(ids, 1), 1);
      chk("run regrant cycles", at(lens, 1), 5);
      // 20 zeros: release right after the 16th
      hard_reset(1);
      for (int i = 0; i < 20; i++) q[2].push_back(0);
      step(50);
      chk("zeros id", at(ids, 0), 2);
      chk("zeros xfers", at(cnts, 0), 16);
      chk("zeros second xfers", at(cnts, 1), 4);
      chk("zeros held grants", ids.size(), 2);
      chk("zeros held g_v", 32'(bus.g_v), 32'd1);
      // 3 tokens then idle: release after 4 idle cycles
      hard_reset(1);
      q[3] = {1, 2, 3};
      step(15);
      chk("idle id", at(ids, 0), 3);
      chk("idle grant cycles", at(lens, 0), 7);
      chk("idle released", 32'(bus.g_v), 32'd0);
      // last token 0: held while idle, other source locked out
      hard_reset(1);
      q[0] = {1, 2, 0};
      q[1] = {5, 5};
      step(40);
      chk("hold grants", ids.size(), 1);
      chk("hold g_id", 32'(bus.g_id), 32'd0);
      chk("hold s_b", 32'(bus.s_b), 32'hE);
      q[0].push_back(4);
      step(15);
      chk("hold xfers", at(cnts, 0), 4);
      chk("hold next id", at(ids, 1), 1);
      // encoder stall mid-burst
      hard_reset(1);
      q[0] = {1, 2, 0, 3, 4, 5, 6, 7, 1, 1};
      step(4);
      eb = 1'b1;
      step(10);
      chk("stall s_b", 32'(bus.s_b), 32'hF);
      eb = 1'b0;
      step(20);
      chk("stall xfers", at(cnts, 0), 8);
      chk("stall grant cycles", at(lens, 0), 18);
      chk("stall regrant id", at(ids, 1), 0);
      // reset mid-grant with owner 3 in a zero run of 5
      hard_reset(1);
      q[3] = {1, 0, 0, 0, 0, 0, 0, 0};
      step(7);
      chk("pre-reset g_id", 32'(bus.g_id), 32'd3);
      q[1] = {2, 2};
      q[2] = {3};
      hard_reset(0);
      step(5);
      chk("post-reset id", at(ids, 0), 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/zle_stream_arb.md
Name: zle_stream_arb

Overview:
- Round-robin arbiter sharing one zero run-length encoder core among N independent 3-bit token streams.
- Sits in front of the encoder's input stream.
- Switches ownership only at run-closed boundaries, so a zero run is never split across sources.
- Publishes the current owner id so downstream logic can attribute encoded output.

Parameters:
- N, 4, number of source streams (2..4).
- BURST, 8, minimum accepted tokens per grant before release is considered (1..255).
- IDLE_MAX, 4, consecutive idle cycles at a boundary after which an idle owner is released (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- s_d  in  3*N  packed source data; source k occupies bits [3k+2:3k].
- s_v  in  N  per-source valid.
- s_b  out  N  per-source backpressure (1 = stall).
- e_d  out  3  data to encoder.
- e_v  out  1  valid to encoder.
- e_b  in  1  encoder backpressure.
- g_v  out  1  grant active.
- g_id  out  2  current owner index.
- sw  out  1  one-cycle pulse on the cycle a new grant begins.

Behaviour:
- Transfer on a cycle = e_v & ~e_b.
- Data path is combinational through the mux; no latency added to the tokens.
  - e_d = s_d[g_id], e_v = g_v & s_v[g_id].
  - s_b[k] = (g_v && k==g_id) ? e_b : 1.
- States:
  - IDLE: g_v=0, all s_b=1, e_v=0.
  - GRANT: g_v=1.
- IDLE -> GRANT when any s_v is high.
  - Winner is the first source with s_v=1, scanning from last+1 modulo N.
  - g_id, g_v and sw take effect on the next clock edge; sw is high for exactly that first GRANT cycle.
  - last is updated to the winner.
- GRANT counters:
  - bcnt (8-bit, saturating) counts transfers.
  - zcnt (4-bit) mirrors the encoder's zero-run count.
    - Transfer of 0 with zcnt<15: zcnt+1.
    - Transfer of 0 with zcnt==15: zcnt wraps to 0 (run emitted by the encoder).
    - Transfer of a nonzero token: zcnt=0.
  - icnt counts consecutive owner cycles with s_v[g_id]=0. It clears on any cycle with s_v high and saturates at IDLE_MAX.
- Boundary means the post-update zcnt==0.
- GRANT -> IDLE at the clock edge ending a cycle in which either:
  - (a) a transfer occurs, bcnt after that transfer >= BURST, and the boundary holds; or
  - (b) zcnt==0 and icnt reaches IDLE_MAX in that cycle.
- Grants are never released while zcnt!=0, regardless of BURST or idle time.
- Leaving GRANT clears bcnt, zcnt and icnt.
- Every grant change passes through one IDLE bubble cycle.
- e_b held high stalls the owner indefinitely; no counter advances without a transfer (icnt still counts only s_v=0 cycles).
- s_v of non-owners is ignored during GRANT; those sources see s_b=1.
- Reset (any time, mid-run included):
  - state=IDLE, g_v=0, g_id=0, sw=0, e_v=0, all s_b=1.
  - bcnt=zcnt=icnt=0.
  - last=N-1, so source 0 wins first.
- Reset is asynchronous assert, synchronous deassert at the register level (no extra synchronizer inside this block).

Test Plan:
- Reset release with s_v=4'b1111, all sources streaming nonzero tokens, e_b=0:
  - g_id sequence 0,1,2,3,0; each grant lasts exactly 8 transfers.
  - One IDLE cycle separates grants; sw pulses once per grant.
- Source 1 alone sends 7 nonzero tokens then 3 zeros then token 5:
  - No release at the 8th token (zcnt=1).
  - Release after the token-5 transfer (11 transfers total).
- Source 2 sends 20 consecutive zeros:
  - zcnt wraps to 0 on the 16th zero; release occurs right after it (bcnt=16>=8).
  - Remaining zeros wait for the next grant.
- Owner sends 3 nonzero tokens then drops s_v:
  - Release after 4 idle cycles.
  - Repeat with the last sent token = 0: grant held indefinitely while s_v=0; others see s_b=1.
- e_b=1 for 10 cycles mid-burst:
  - s_b[g_id]=1 throughout; bcnt and zcnt frozen; grant unchanged.
- reset pulsed low mid-GRANT (g_id=3, zcnt=5):
  - Immediately g_v=0, e_v=0, s_b=4'b1111.
  - After release, first grant goes to the lowest-index valid source.
